clock_divider_multi: RTL and testbench
======================================

// Module: clock_divider_multi
// PURPOSE
//  - N-channel programmable clock divider; successor to the fixed single-output divider.
//  - Divisors are loaded at run time, per channel, through a write port. Each channel has
//    its own enable, a divided clock output and a one-cycle tick strobe.
//  - Feeds processor, display and peripheral slow clocks from the single FPGA clock.
//  - Divisor changes are glitch-free: applied only at a period boundary.
// PARAMETERS
//  NCH          4                  number of channels (1..16)
//  CW           28                 counter/divisor width in bits
//  DEFAULT_DIV  28'd10_000_000     divisor loaded into every channel at reset (period in clocks)
//  CHW          (NCH>1?$clog2(NCH):1)  channel-select width (derived, do not override)
// PORTS
//  clock_in   in   1        FPGA clock; the only clock
//  reset      in   1        synchronous, active-high reset
//  en         in   NCH      per-channel run enable
//  wr_en      in   1        divisor write strobe (single cycle, no backpressure)
//  wr_chan    in   CHW      target channel of write
//  wr_data    in   CW       new divisor D (period in clock_in cycles)
//  wr_err     out  1        1-cycle pulse: previous-cycle write rejected
//  clock_out  out  NCH      divided clocks, registered
//  tick       out  NCH      1-cycle strobe per period, registered
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Per-channel state: cnt[CW], act_div[CW], shd_div[CW], pend (1 bit).
//  - Reset (sampled at a clock_in edge): for every channel
//    - cnt=0, act_div=shd_div=DEFAULT_DIV, pend=0
//    - clock_out=0, tick=0, wr_err=0
//    - Reset overrides any write or enable in the same cycle.
//  - Counting (en[i]=1):
//    - cnt <= (cnt==act_div-1) ? 0 : cnt+1
//    - The cycle where cnt==act_div-1 is the "wrap".
//  - Outputs (registered, consistent with current cnt/act_div every cycle):
//    - clock_out[i] == (cnt >= act_div>>1), i.e. low floor(D/2) cycles, then high ceil(D/2)
//      cycles. Example: D=5 gives 2 low, 3 high.
//    - tick[i] == (cnt == act_div>>1): exactly one cycle per period, coincident with the
//      first high cycle of clock_out.
//  - Disabled (en[i]=0):
//    - cnt held at 0; clock_out[i]=0; tick[i]=0.
//    - When en rises, counting starts from cnt=0.
//  - Write accepted when wr_en=1, wr_chan<NCH and wr_data>=2:
//    - shd_div <= wr_data and pend <= 1 at the next edge.
//  - Write rejected when wr_data<2 or wr_chan>=NCH:
//    - No state changes; wr_err=1 in the following cycle only.
//  - Apply pending divisor:
//    - At a wrap with pend=1: act_div <= shd_div, pend <= 0; the new period starts at cnt=0.
//    - If the channel is disabled with pend=1: act_div <= shd_div on the next edge.
//  - Simultaneous accepted write and wrap, same channel:
//    - act_div takes the old shd_div.
//    - shd_div takes wr_data; pend stays 1, so the new value applies at the next wrap.
//  - Latency: a write at edge t is visible in shd_div at t+1 and in act_div at the first wrap
//    at or after t+1. A period in progress is never truncated or stretched.
//  - Writes to one channel never disturb the other channels.
//  - Reset mid-period: outputs drop to 0 on the reset edge; every divisor reverts to
//    DEFAULT_DIV; pending writes are lost.
//  - Arithmetic: all unsigned CW-bit. act_div>=2 always, so act_div-1 never underflows.
// STRUCTURE
//  - clkdiv_defs.vh holds shared constants: MIN_DIV=2, default CW/NCH values.
//  - Sub-module clkdiv_channel (one per channel, generate loop):
//    - holds cnt/act_div/shd_div/pend and produces clock_out/tick;
//    - ports: clock_in, reset, en, ld (accepted write), ld_data.
//  - Top level: write decode, range checks, wr_err register.
// TESTING
//  1. Reset defaults: NCH=2, DEFAULT_DIV=6, en=2'b11 after reset
//     -> each clock_out is 3 low / 3 high; tick pulses every 6 cycles on the first high cycle.
//  2. Odd divisor: write ch0 D=5 while idle (en=0), then enable
//     -> clock_out[0] pattern 0,0,1,1,1 repeating; tick[0] on the 3rd cycle of each period.
//  3. Glitch-free update: ch0 running D=8, write D=4 at cnt=2
//     -> current period completes 8 cycles, then periods of 4; no short pulse.
//  4. Write on the wrap cycle: ch1 D=6; write D=10, then write D=3 in the wrap cycle
//     -> next period is 10, the following period is 3.
//  5. Rejects: write D=1, write D=0, and wr_chan=3 with NCH=3
//     -> wr_err pulses 1 cycle each time; the channel's period is unchanged.
//  6. Reset mid-operation: assert reset during a high phase with a write pending
//     -> clock_out=0 and tick=0 next edge; after release, period = DEFAULT_DIV.

Source files
------------

// File: rtl/clock_divider_multi_pkg.sv
// Shared constants for the multi-channel programmable clock divider.
// Imported by the channel sub-module and the top level.
package clock_divider_multi_pkg;

   localparam int MIN_DIV = 2;
   localparam int DEF_CW  = 28;
   localparam int DEF_NCH = 4;
   localparam int DEF_DIV = 10_000_000;

endpackage

// File: rtl/clock_divider_multi_channel.sv
// One divider channel: period counter plus active/shadow divisor pair.
// A new divisor waits in the shadow register until a period boundary.
module clock_divider_multi_channel
   import clock_divider_multi_pkg::*;
#(
   parameter int              CW          = DEF_CW,
   parameter logic [CW-1:0]   DEFAULT_DIV = CW'(DEF_DIV)
) (
   input  logic          clock_in,
   input  logic          reset,
   input  logic          en,
   input  logic          ld,
   input  logic [CW-1:0] ld_data,
   output logic          clock_out,
   output logic          tick
);

   localparam logic [CW-1:0] ONE = CW'(1);

   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] act_div, act_nxt;
   logic [CW-1:0] shd_div, shd_nxt;
   logic [CW-1:0] half_nxt;
   logic          pend, pend_nxt;
   logic          apply;

   // A disabled channel is always at a boundary, so a pending divisor lands at once.
   always_comb begin
      cnt_nxt  = cnt;
      act_nxt  = act_div;
      shd_nxt  = shd_div;
      pend_nxt = pend;
      apply    = 1'b0;
      if (!en) begin
         cnt_nxt = '0;
         apply   = pend;
      end else if (cnt == act_div - ONE) begin
         cnt_nxt = '0;
         apply   = pend;
      end else begin
         cnt_nxt = cnt + ONE;
      end
      if (apply) begin
         act_nxt  = shd_div;
         pend_nxt = 1'b0;
      end
      if (ld) begin
         shd_nxt  = ld_data;
         pend_nxt = 1'b1;
      end
      half_nxt = act_nxt >> 1;
   end

   // Outputs are decoded from the next count so they line up with the registered state.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         cnt       <= '0;
         act_div   <= DEFAULT_DIV;
         shd_div   <= DEFAULT_DIV;
         pend      <= 1'b0;
         clock_out <= 1'b0;
         tick      <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         act_div   <= act_nxt;
         shd_div   <= shd_nxt;
         pend      <= pend_nxt;
         clock_out <= (cnt_nxt >= half_nxt);
         tick      <= (cnt_nxt == half_nxt);
      end
   end

endmodule

// File: rtl/clock_divider_multi.sv
// N-channel programmable clock divider: write decode, range checks and
// the write-error strobe around one divider channel per output.
module clock_divider_multi
   import clock_divider_multi_pkg::*;
#(
   parameter int            NCH         = DEF_NCH,
   parameter int            CW          = DEF_CW,
   parameter logic [CW-1:0] DEFAULT_DIV = CW'(DEF_DIV),
   localparam int           CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clock_in,
   input  logic           reset,
   input  logic [NCH-1:0] en,
   input  logic           wr_en,
   input  logic [CHW-1:0] wr_chan,
   input  logic [CW-1:0]  wr_data,
   output logic           wr_err,
   output logic [NCH-1:0] clock_out,
   output logic [NCH-1:0] tick
);

   logic chan_ok;
   logic data_ok;
   logic accept;

   assign chan_ok = 32'(wr_chan) < 32'(NCH);
   assign data_ok = wr_data >= CW'(MIN_DIV);
   assign accept  = wr_en && chan_ok && data_ok;

   // A rejected write leaves every channel untouched and only raises this strobe.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !accept;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic ld;
      assign ld = accept && (32'(wr_chan) == 32'(i));

      clock_divider_multi_channel #(
         .CW          (CW),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_channel (
         .clock_in  (clock_in),
         .reset     (reset),
         .en        (en[i]),
         .ld        (ld),
         .ld_data   (wr_data),
         .clock_out (clock_out[i]),
         .tick      (tick[i])
      );
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: a phase/period model checked every
// cycle, plus directed scenarios with hand-computed periods and waveforms.
module tb_clock_divider_multi;

   localparam int NCH  = 3;
   localparam int CW   = 8;
   localparam int DDIV = 6;

   logic           clock_in = 1'b0;
   logic           reset;
   logic [NCH-1:0] en;
   logic           wr_en;
   logic [1:0]     wr_chan;
   logic [CW-1:0]  wr_data;
   logic           wr_err;
   logic [NCH-1:0] clock_out;
   logic [NCH-1:0] tick;

   int compared   = 0;
   int mismatched = 0;

   // Model state: position inside the current period and the period length in force.
   int  m_phase  [NCH];
   int  m_period [NCH];
   int  m_shadow [NCH];
   bit  m_pend   [NCH];
   bit  m_err;
   bit  m_valid = 1'b0;

   int             fall_cyc [NCH][$];
   logic [NCH-1:0] prev_clk = '0;
   int             cyc = 0;

   bit pat_clk  [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
   bit pat_tick [10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};

   clock_divider_multi #(
      .NCH         (NCH),
      .CW          (CW),
      .DEFAULT_DIV (8'd6)
   ) dut (
      .clock_in  (clock_in),
      .reset     (reset),
      .en        (en),
      .wr_en     (wr_en),
      .wr_chan   (wr_chan),
      .wr_data   (wr_data),
      .wr_err    (wr_err),
      .clock_out (clock_out),
      .tick      (tick)
   );

   always #5 clock_in = ~clock_in;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic applyStimulus(input int chan, input int data);
      wr_en   = 1'b1;
      wr_chan = 2'(chan);
      wr_data = CW'(data);
      step(1);
      wr_en   = 1'b0;
   endtask

   function automatic int interval(input int c, input int k);
      if (fall_cyc[c].size() > k + 1) return fall_cyc[c][k+1] - fall_cyc[c][k];
      return -1;
   endfunction

   task automatic clearFalls(input int c);
      fall_cyc[c].delete();
   endtask

   // Behavioural model: a period ends when the phase has advanced through all of it.
   always @(posedge clock_in) begin
      if (reset) begin
         for (int c = 0; c < NCH; c++) begin
            m_phase[c]  <= 0;
            m_period[c] <= DDIV;
            m_shadow[c] <= DDIV;
            m_pend[c]   <= 1'b0;
         end
         m_err   <= 1'b0;
         m_valid <= 1'b1;
      end else begin
         m_err <= wr_en && (int'(wr_chan) >= NCH || int'(wr_data) < 2);
         for (int c = 0; c < NCH; c++) begin
            int ph, per, shd;
            bit pd;
            bit boundary;
            ph  = m_phase[c];
            per = m_period[c];
            shd = m_shadow[c];
            pd  = m_pend[c];
            boundary = (en[c] == 1'b0) || (ph + 1 == per);
            ph = boundary ? 0 : ph + 1;
            if (boundary && pd) begin
               per = shd;
               pd  = 1'b0;
            end
            if (wr_en && int'(wr_chan) == c && int'(wr_data) >= 2) begin
               shd = int'(wr_data);
               pd  = 1'b1;
            end
            m_phase[c]  <= ph;
            m_period[c] <= per;
            m_shadow[c] <= shd;
            m_pend[c]   <= pd;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clock_in) begin
      if (m_valid) begin
         for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("model clock_out[%0d]", c), 32'(clock_out[c]),
                        32'(m_phase[c] >= m_period[c] / 2));
            checkOutput($sformatf("model tick[%0d]", c), 32'(tick[c]),
                        32'(m_phase[c] == m_period[c] / 2));
         end
         checkOutput("model wr_err", 32'(wr_err), 32'(m_err));
      end
   end

   // Falling edges of clock_out mark the start of each period.
   always @(negedge clock_in) begin
      cyc <= cyc + 1;
      for (int c = 0; c < NCH; c++) begin
         if (prev_clk[c] === 1'b1 && clock_out[c] === 1'b0) fall_cyc[c].push_back(cyc);
      end
      prev_clk <= clock_out;
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      reset   = 1'b1;
      en      = '0;
      wr_en   = 1'b0;
      wr_chan = '0;
      wr_data = '0;
      step(3);
      checkOutput("reset clock_out", 32'(clock_out), 32'd0);
      checkOutput("reset tick", 32'(tick), 32'd0);
      checkOutput("reset wr_err", 32'(wr_err), 32'd0);

      $display("[TB] scenario 1: default divisor");
      reset = 1'b0;
      en    = 3'b111;
      for (int c = 0; c < NCH; c++) clearFalls(c);
      step(14);
      checkOutput("s1 ch0 period", interval(0, 0), 6);
      checkOutput("s1 ch1 period", interval(1, 0), 6);

      $display("[TB] scenario 2: odd divisor loaded while idle");
      en[0] = 1'b0;
      applyStimulus(0, 5);
      step(1);
      en[0] = 1'b1;
      step(1);
      for (int k = 0; k < 10; k++) begin
         checkOutput($sformatf("s2 clock_out[0] #%0d", k), 32'(clock_out[0]), 32'(pat_clk[k]));
         checkOutput($sformatf("s2 tick[0] #%0d", k), 32'(tick[0]), 32'(pat_tick[k]));
         step(1);
      end

      $display("[TB] scenario 3: glitch-free divisor change");
      en[0] = 1'b0;
      applyStimulus(0, 8);
      step(1);
      clearFalls(0);
      en[0] = 1'b1;
      step(10);
      applyStimulus(0, 4);
      step(16);
      checkOutput("s3 period before change", interval(0, 0), 8);
      checkOutput("s3 first new period", interval(0, 1), 4);
      checkOutput("s3 second new period", interval(0, 2), 4);

      $display("[TB] scenario 4: write on the wrap cycle");
      en[1] = 1'b0;
      step(2);
      clearFalls(1);
      en[1] = 1'b1;
      step(2);
      applyStimulus(1, 10);
      step(2);
      applyStimulus(1, 3);
      step(18);
      checkOutput("s4 period 10", interval(1, 0), 10);
      checkOutput("s4 period 3a", interval(1, 1), 3);
      checkOutput("s4 period 3b", interval(1, 2), 3);

      $display("[TB] scenario 5: rejected writes");
      applyStimulus(0, 1);
      checkOutput("s5 err D=1", 32'(wr_err), 32'd1);
      step(1);
      checkOutput("s5 err clear 1", 32'(wr_err), 32'd0);
      applyStimulus(0, 0);
      checkOutput("s5 err D=0", 32'(wr_err), 32'd1);
      step(1);
      checkOutput("s5 err clear 2", 32'(wr_err), 32'd0);
      applyStimulus(3, 7);
      checkOutput("s5 err chan=3", 32'(wr_err), 32'd1);
      step(1);
      checkOutput("s5 err clear 3", 32'(wr_err), 32'd0);
      clearFalls(0);
      step(14);
      checkOutput("s5 ch0 period kept a", interval(0, 0), 4);
      checkOutput("s5 ch0 period kept b", interval(0, 1), 4);

      $display("[TB] scenario 6: reset mid-period with a pending write");
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (tick[0] === 1'b1) found = 1'b1;
         else step(1);
      end
      checkOutput("s6 tick[0] seen", 32'(found), 32'd1);
      applyStimulus(0, 9);
      checkOutput("s6 high before reset", 32'(clock_out[0]), 32'd1);
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_chan = 2'd2;
      wr_data = 8'd2;
      step(1);
      wr_en = 1'b0;
      checkOutput("s6 clock_out after reset", 32'(clock_out), 32'd0);
      checkOutput("s6 tick after reset", 32'(tick), 32'd0);
      checkOutput("s6 wr_err after reset", 32'(wr_err), 32'd0);
      reset = 1'b0;
      for (int c = 0; c < NCH; c++) clearFalls(c);
      step(14);
      checkOutput("s6 ch0 default period", interval(0, 0), 6);
      checkOutput("s6 ch1 default period", interval(1, 0), 6);
      checkOutput("s6 ch2 default period", interval(2, 0), 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
